// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 pooling window feeder.
package pool_pkg;

  localparam int DATA_W_DEF = 16;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } fsm_state_t;

  // Index width for a counter or address spanning n entries; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single synchronous write port, two combinational read ports.
// Contents are deliberately not reset; every entry is rewritten before it is read.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH  = 28,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Turns a raster pixel stream into registered 2x2 windows for the pooling stage.
// Optional macro POOL_FEED_FRAME_CHK_EN adds a sticky in_last/frame alignment check (frame_err).
module pool_window_feeder
  import pool_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_last,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win_00,
  output logic [DATA_W-1:0] win_01,
  output logic [DATA_W-1:0] win_10,
  output logic [DATA_W-1:0] win_11,
  output logic              win_last
`ifdef POOL_FEED_FRAME_CHK_EN
  ,
  output logic              frame_err
`endif
);

  localparam int COL_W = idx_w(IMG_W);
  localparam int ROW_W = idx_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  fsm_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] lb_prev, lb_cur;
  logic              in_xfer, win_xfer;
  logic              lb_we, hold_we, load_win;
  logic              row_end, frame_end;

  assign in_xfer   = in_valid && in_ready;
  assign win_xfer  = win_valid && win_ready;
  assign row_end   = (col_q == COL_LAST);
  assign frame_end = row_end && (row_q == ROW_LAST);

  pool_line_buf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (lb_we),
    .wr_addr   (col_q),
    .wr_data   (in_pixel),
    .rd_addr_a (col_q - COL_W'(1)),
    .rd_addr_b (col_q),
    .rd_data_a (lb_prev),
    .rd_data_b (lb_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the odd column of an odd row completes a window, so only that pixel can stall.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    lb_we    = 1'b0;
    hold_we  = 1'b0;
    load_win = 1'b0;
    case (state_q)
      FILL: begin
        lb_we = in_valid;
        if (in_valid && row_end) begin
          state_d = PAIR;
        end
      end
      PAIR: begin
        if (col_q[0]) begin
          in_ready = !win_valid || win_ready;
          load_win = in_valid && in_ready;
        end else begin
          hold_we = in_valid;
        end
        if (in_valid && in_ready && row_end) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_xfer) begin
      if (row_end) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (hold_we) begin
      hold_q <= in_pixel;
    end
  end

  // A load takes priority over a consume, so a window can be replaced without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_00    <= '0;
      win_01    <= '0;
      win_10    <= '0;
      win_11    <= '0;
    end else if (load_win) begin
      win_valid <= 1'b1;
      win_last  <= frame_end;
      win_00    <= lb_prev;
      win_01    <= lb_cur;
      win_10    <= hold_q;
      win_11    <= in_pixel;
    end else if (win_xfer) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

`ifdef POOL_FEED_FRAME_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (in_xfer && (in_last != frame_end)) begin
      frame_err <= 1'b1;
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// Randomized self-checking bench for pool_window_feeder on a 4x4 map.
// Define POOL_FEED_FRAME_CHK_EN to also exercise frame_err.
module tb_pool_window_feeder;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int DW    = 16;
  localparam int FRAME = W * H;
  localparam int NWIN  = (W / 2) * (H / 2);

  typedef struct {
    logic [DW-1:0] d00, d01, d10, d11;
    logic          last;
    int            cyc;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_pixel = '0;
  logic          in_last = 1'b0;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [DW-1:0] win_00, win_01, win_10, win_11;
  logic          win_last;
`ifdef POOL_FEED_FRAME_CHK_EN
  logic          frame_err;
  int            fe_rise_cyc;
`endif

  logic [DW-1:0] stream[$];
  win_t          got[$];
  win_t          exp_q[$];
  int            px_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            blocked_idx;
  int            unstable;
  int            valid_rises;
  bit            timed_out;

  pool_window_feeder #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_last   (in_last),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_00    (win_00),
    .win_01    (win_01),
    .win_10    (win_10),
    .win_11    (win_11),
    .win_last  (win_last)
`ifdef POOL_FEED_FRAME_CHK_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: every 2x2 tile of each frame, in raster order of the tile grid.
  function automatic void build_model();
    exp_q.delete();
    for (int f = 0; f < stream.size() / FRAME; f++) begin
      for (int wr = 0; wr < H / 2; wr++) begin
        for (int wc = 0; wc < W / 2; wc++) begin
          int   b;
          win_t w;
          b      = f * FRAME + 2 * wr * W + 2 * wc;
          w.d00  = stream[b];
          w.d01  = stream[b + 1];
          w.d10  = stream[b + W];
          w.d11  = stream[b + W + 1];
          w.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
          w.cyc  = 0;
          exp_q.push_back(w);
        end
      end
    end
  endfunction

  // Index (within the stream) of the pixel that completes window k.
  function automatic int closing_pixel(input int k);
    int f, wr, wc;
    f  = k / NWIN;
    wr = (k % NWIN) / (W / 2);
    wc = (k % NWIN) % (W / 2);
    return f * FRAME + (2 * wr + 1) * W + 2 * wc + 1;
  endfunction

  task automatic assert_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    in_last   = 1'b0;
    repeat (2) @(posedge clk);
    #4;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives the queued stream and records every window transfer; starts and ends at posedge+1.
  task automatic applyStimulus(input int valid_pct, input int ready_pct, input int hold_until,
                               input int bad_last_idx, input bit drain, input int budget);
    int            idx;
    int            cyc;
    bit            held;
    bit            prev_valid;
    logic [4*DW-1:0] prev_data;
    idx = 0; cyc = 0; held = 0; prev_valid = 0; prev_data = '0;
    got.delete(); px_cyc.delete();
    blocked_idx = -1; unstable = 0; valid_rises = 0;
`ifdef POOL_FEED_FRAME_CHK_EN
    fe_rise_cyc = -1;
`endif
    while ((idx < stream.size() || (drain && win_valid === 1'b1)) && cyc < budget) begin
      in_valid  = (idx < stream.size()) && ($urandom_range(99) < valid_pct);
      in_pixel  = in_valid ? stream[idx] : '0;
      in_last   = in_valid && (((idx % FRAME) == FRAME - 1) != (idx == bad_last_idx));
      win_ready = (cyc >= hold_until) && ($urandom_range(99) < ready_pct);
      #4;
      if (held && win_valid && ({win_00, win_01, win_10, win_11} !== prev_data)) unstable++;
      if (win_valid && !prev_valid) valid_rises++;
      if (in_valid && !in_ready && blocked_idx < 0) blocked_idx = idx;
`ifdef POOL_FEED_FRAME_CHK_EN
      if (frame_err === 1'b1 && fe_rise_cyc < 0) fe_rise_cyc = cyc;
`endif
      if (win_valid && win_ready) begin
        win_t w;
        w.d00 = win_00; w.d01 = win_01; w.d10 = win_10; w.d11 = win_11;
        w.last = win_last; w.cyc = cyc;
        got.push_back(w);
      end
      held       = win_valid && !win_ready;
      prev_valid = win_valid;
      prev_data  = {win_00, win_01, win_10, win_11};
      if (in_valid && in_ready) begin
        px_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    win_ready = 1'b0;
    timed_out = (idx < stream.size()) || (drain && win_valid === 1'b1);
  endtask

  task automatic load_seq(input int first, input int count);
    stream.delete();
    for (int i = 0; i < count; i++) stream.push_back(DW'(first + i));
  endtask

  task automatic test_reset();
    assert_reset();
    total++;
    if ({win_valid, win_last} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_flags: got valid/last=%b%b, want 00", win_valid, win_last);
    end
    total++;
    if ({win_00, win_01, win_10, win_11} !== '0) begin
      bad++; $display("[TB] FAIL reset_data: got %h %h %h %h, want zeros", win_00, win_01, win_10, win_11);
    end
`ifdef POOL_FEED_FRAME_CHK_EN
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_frame_err: got %b, want 0", frame_err);
    end
`endif
    release_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    assert_reset(); release_reset();
    load_seq(1, FRAME); build_model();
    applyStimulus(100, 100, 0, -1, 1, 500);
    total++;
    if (timed_out || got.size() != NWIN) begin
      bad++; $display("[TB] FAIL basic_count: got %0d windows (timeout=%0b), want %0d", got.size(), timed_out, NWIN);
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last} !==
          {exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last}) begin
        bad++; $display("[TB] FAIL basic_win%0d: got %0d %0d %0d %0d last=%b, want %0d %0d %0d %0d last=%b", k,
          got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last,
          exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last);
      end
      total++;
      if (got[k].cyc != px_cyc[closing_pixel(k)] + 1) begin
        bad++; $display("[TB] FAIL basic_lat%0d: got cycle %0d, want %0d", k, got[k].cyc, px_cyc[closing_pixel(k)] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    assert_reset(); release_reset();
    load_seq(1, FRAME); build_model();
    // Pixel 6 is accepted in cycle 5, so the consumer wakes in cycle 15.
    applyStimulus(100, 100, 15, -1, 1, 500);
    total++;
    if (timed_out || got.size() != NWIN || px_cyc.size() != FRAME) begin
      bad++; $display("[TB] FAIL bp_count: got %0d windows %0d pixels, want %0d and %0d", got.size(), px_cyc.size(), NWIN, FRAME);
    end
    total++;
    if (got.size() > 0 && got[0].cyc != px_cyc[5] + 10) begin
      bad++; $display("[TB] FAIL bp_first_take: got cycle %0d, want %0d", got[0].cyc, px_cyc[5] + 10);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("[TB] FAIL bp_stable: got %0d data changes while held, want 0", unstable);
    end
    total++;
    if (blocked_idx != 7) begin
      bad++; $display("[TB] FAIL bp_stall_pixel: got first stall at index %0d, want 7", blocked_idx);
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last} !==
          {exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last}) begin
        bad++; $display("[TB] FAIL bp_win%0d: got %0d %0d %0d %0d, want %0d %0d %0d %0d", k,
          got[k].d00, got[k].d01, got[k].d10, got[k].d11, exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11);
      end
    end
  endtask

  task automatic test_constant();
    assert_reset(); release_reset();
    stream.delete();
    for (int i = 0; i < FRAME; i++) stream.push_back(16'h0004);
    applyStimulus(100, 100, 0, -1, 1, 500);
    total++;
    if (timed_out || got.size() != NWIN || valid_rises != NWIN) begin
      bad++; $display("[TB] FAIL const_starts: got %0d windows %0d starts, want %0d", got.size(), valid_rises, NWIN);
    end
    for (int k = 0; k < got.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11} !== {4{16'h0004}}) begin
        bad++; $display("[TB] FAIL const_win%0d: got %h %h %h %h, want all 0004", k, got[k].d00, got[k].d01, got[k].d10, got[k].d11);
      end
    end
  endtask

  task automatic test_mid_reset();
    assert_reset(); release_reset();
    load_seq(1, 7);
    applyStimulus(100, 0, 0, -1, 0, 50);
    assert_reset();
    total++;
    if (win_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_valid: got %b during reset, want 0", win_valid);
    end
    release_reset();
    load_seq(1, FRAME); build_model();
    applyStimulus(100, 100, 0, -1, 1, 500);
    total++;
    if (timed_out || got.size() != NWIN) begin
      bad++; $display("[TB] FAIL midrst_count: got %0d windows, want %0d", got.size(), NWIN);
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last} !==
          {exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last} ||
          got[k].cyc != px_cyc[closing_pixel(k)] + 1) begin
        bad++; $display("[TB] FAIL midrst_win%0d: got %0d %0d %0d %0d last=%b at %0d, want %0d %0d %0d %0d last=%b at %0d", k,
          got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last, got[k].cyc,
          exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last, px_cyc[closing_pixel(k)] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    assert_reset(); release_reset();
    load_seq(1, 2 * FRAME); build_model();
    applyStimulus(100, 100, 0, -1, 1, 500);
    total++;
    if (timed_out || got.size() != 2 * NWIN) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d windows, want %0d", got.size(), 2 * NWIN);
    end
    total++;
    if (px_cyc.size() == 2 * FRAME && px_cyc[FRAME] != px_cyc[FRAME - 1] + 1) begin
      bad++; $display("[TB] FAIL b2b_gap: got second frame at cycle %0d, want %0d", px_cyc[FRAME], px_cyc[FRAME - 1] + 1);
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last} !==
          {exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last}) begin
        bad++; $display("[TB] FAIL b2b_win%0d: got %0d %0d %0d %0d last=%b, want %0d %0d %0d %0d last=%b", k,
          got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last,
          exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last);
      end
    end
  endtask

  task automatic test_random();
    assert_reset(); release_reset();
    stream.delete();
    for (int i = 0; i < 3 * FRAME; i++) stream.push_back(DW'($urandom));
    build_model();
    applyStimulus(70, 60, 0, -1, 1, 2000);
    total++;
    if (timed_out || got.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL rand_count: got %0d windows (timeout=%0b), want %0d", got.size(), timed_out, exp_q.size());
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("[TB] FAIL rand_stable: got %0d data changes while held, want 0", unstable);
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      total++;
      if ({got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last} !==
          {exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last}) begin
        bad++; $display("[TB] FAIL rand_win%0d: got %h %h %h %h last=%b, want %h %h %h %h last=%b", k,
          got[k].d00, got[k].d01, got[k].d10, got[k].d11, got[k].last,
          exp_q[k].d00, exp_q[k].d01, exp_q[k].d10, exp_q[k].d11, exp_q[k].last);
      end
    end
`ifdef POOL_FEED_FRAME_CHK_EN
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rand_frame_err: got %b with aligned in_last, want 0", frame_err);
    end
`endif
  endtask

`ifdef POOL_FEED_FRAME_CHK_EN
  task automatic test_frame_err();
    assert_reset(); release_reset();
    load_seq(1, FRAME);
    applyStimulus(100, 100, 0, 9, 1, 500);
    total++;
    if (px_cyc.size() != FRAME || fe_rise_cyc != px_cyc[9] + 1) begin
      bad++; $display("[TB] FAIL ferr_rise: got rise at cycle %0d, want %0d", fe_rise_cyc,
        (px_cyc.size() > 9) ? px_cyc[9] + 1 : -1);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (frame_err !== 1'b1) begin
      bad++; $display("[TB] FAIL ferr_sticky: got %b, want 1", frame_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_constant();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef POOL_FEED_FRAME_CHK_EN
    test_frame_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
